combo_lock_param: RTL and testbench

Parametrised keypad combination lock, next generation of the team's fixed 4-digit, 10-key lock. Digit count, key count, failed-attempt limit and lockout duration are parameters. Adds explicit entry-length checking, multi-key rejection and a timed lockout after repeated failures. Sits between the debounced keypad/button front end and the actuator/status logic.

---
 rtl/combo_lock_param.sv | 188 ++++++++++++++++++
 tb/tb_combo_lock_param.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/combo_lock_param.sv
// Parametrised keypad combination lock with entry-length checking and multi-key rejection.
// Optional timed lockout after MAX_TRIES consecutive failures: define COMBO_LOCK_LOCKOUT_EN.
module combo_lock_param #(
  parameter int DIGITS         = 4,
  parameter int KEYS           = 10,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic            clk,
  input  logic            hard_rst_n,
  input  logic [KEYS-1:0] keypad,
  input  logic            enter,
  input  logic            prog,
  input  logic            clr,
  output logic            unlock,
  output logic            incorrect,
  output logic            lockout,
  output logic [15:0]     try_monitor,
  output logic            press_monitor
);

  localparam int DW = $clog2(KEYS);
  localparam int BW = DIGITS * DW;
  localparam int CW = $clog2(DIGITS + 2);
  localparam int FW = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {S_LOCKED, S_UNLOCKED, S_PROGRAM, S_LOCKOUT} state_t;

  state_t          state_q, state_d;
  logic [KEYS-1:0] key_prev_q;
  logic            enter_prev_q, prog_prev_q, clr_prev_q;
  logic [BW-1:0]   buf_q, buf_d, pwd_q, pwd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            inv_q, inv_d;
  logic [FW-1:0]   fail_q, fail_d, fail_inc;
  logic [15:0]     try_q, try_d;
  logic            inc_q, inc_d, press_q, press_d;
  logic            key_ev, enter_ev, prog_ev, clr_ev, clear_entry, entry_ok;

  function automatic logic [DW-1:0] key_index(input logic [KEYS-1:0] k);
    key_index = '0;
    for (int i = 0; i < KEYS; i++)
      if (k[i]) key_index = DW'(i);
  endfunction

  assign key_ev   = (key_prev_q == '0) && (keypad != '0);
  assign enter_ev = enter & ~enter_prev_q;
  assign prog_ev  = prog & ~prog_prev_q;
  assign clr_ev   = clr & ~clr_prev_q;
  assign entry_ok = (cnt_q == CW'(DIGITS)) && !inv_q;
  assign fail_inc = (fail_q == FW'(MAX_TRIES)) ? fail_q : fail_q + FW'(1);

`ifdef COMBO_LOCK_LOCKOUT_EN
  localparam int LW = $clog2(LOCKOUT_CYCLES);
  logic [LW-1:0] lo_cnt_q, lo_cnt_d;
`else
  logic [31:0] unused_lockout_cycles;
  assign unused_lockout_cycles = LOCKOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    inv_d       = inv_q;
    pwd_d       = pwd_q;
    fail_d      = fail_q;
    try_d       = try_q;
    inc_d       = inc_q;
    press_d     = 1'b0;
    clear_entry = 1'b0;
`ifdef COMBO_LOCK_LOCKOUT_EN
    lo_cnt_d    = lo_cnt_q;
`endif
    if (state_q == S_LOCKOUT) begin
`ifdef COMBO_LOCK_LOCKOUT_EN
      if (lo_cnt_q == '0) begin
        state_d = S_LOCKED;
        fail_d  = '0;
      end else begin
        lo_cnt_d = lo_cnt_q - LW'(1);
      end
`else
      state_d = S_LOCKED;
`endif
    end else if (clr_ev) begin
      clear_entry = 1'b1;
      inc_d       = 1'b0;
    end else if (enter_ev) begin
      clear_entry = 1'b1;
      case (state_q)
        S_LOCKED: begin
          if (entry_ok && (buf_q == pwd_q)) begin
            state_d = S_UNLOCKED;
            fail_d  = '0;
          end else begin
            inc_d  = 1'b1;
            try_d  = (try_q == 16'hFFFF) ? try_q : try_q + 16'd1;
            fail_d = fail_inc;
`ifdef COMBO_LOCK_LOCKOUT_EN
            if (fail_inc == FW'(MAX_TRIES)) begin
              state_d  = S_LOCKOUT;
              lo_cnt_d = LW'(LOCKOUT_CYCLES - 1);
            end
`endif
          end
        end
        S_UNLOCKED: state_d = S_LOCKED;
        S_PROGRAM: begin
          if (entry_ok) begin
            pwd_d   = buf_q;
            state_d = S_LOCKED;
          end else begin
            inc_d = 1'b1;
          end
        end
        default: state_d = S_LOCKED;
      endcase
    end else if (prog_ev) begin
      clear_entry = 1'b1;
      if (state_q == S_UNLOCKED) state_d = S_PROGRAM;
    end else if (key_ev) begin
      press_d = 1'b1;
      inc_d   = 1'b0;
      if (cnt_q != CW'(DIGITS + 1)) cnt_d = cnt_q + CW'(1);
      if ($onehot(keypad)) buf_d = (buf_q << DW) | BW'(key_index(keypad));
      else                 inv_d = 1'b1;
    end
    // incorrect survives only the transition into LOCKOUT
    if (state_d != state_q) begin
      clear_entry = 1'b1;
      if (state_d != S_LOCKOUT) inc_d = 1'b0;
    end
    if (clear_entry) begin
      buf_d = '0;
      cnt_d = '0;
      inv_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!hard_rst_n) begin
      state_q      <= S_LOCKED;
      key_prev_q   <= '0;
      enter_prev_q <= 1'b0;
      prog_prev_q  <= 1'b0;
      clr_prev_q   <= 1'b0;
      buf_q        <= '0;
      pwd_q        <= '0;
      cnt_q        <= '0;
      inv_q        <= 1'b0;
      fail_q       <= '0;
      try_q        <= '0;
      inc_q        <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_prev_q   <= keypad;
      enter_prev_q <= enter;
      prog_prev_q  <= prog;
      clr_prev_q   <= clr;
      buf_q        <= buf_d;
      pwd_q        <= pwd_d;
      cnt_q        <= cnt_d;
      inv_q        <= inv_d;
      fail_q       <= fail_d;
      try_q        <= try_d;
      inc_q        <= inc_d;
      press_q      <= press_d;
    end
  end

`ifdef COMBO_LOCK_LOCKOUT_EN
  always_ff @(posedge clk) begin
    if (!hard_rst_n) lo_cnt_q <= '0;
    else             lo_cnt_q <= lo_cnt_d;
  end
  assign lockout = (state_q == S_LOCKOUT);
`else
  assign lockout = 1'b0;
`endif

  assign unlock        = (state_q == S_UNLOCKED);
  assign incorrect     = inc_q;
  assign try_monitor   = try_q;
  assign press_monitor = press_q;

endmodule

// File: tb/tb_combo_lock_param.sv
// Directed bench for combo_lock_param (4 digits, 10 keys, 3 tries, 20-cycle lockout).
module tb_combo_lock_param;

  localparam int KEYS = 10;

  logic            clk = 1'b0;
  logic            hard_rst_n;
  logic [KEYS-1:0] keypad;
  logic            enter, prog, clr;
  logic            unlock, incorrect, lockout, press_monitor;
  logic [15:0]     try_monitor;

  int n_assert = 0;
  int n_fail   = 0;
  int press_cnt = 0;
  int lo_high_cnt = 0;
  int snap;

  combo_lock_param #(.DIGITS(4), .KEYS(KEYS), .MAX_TRIES(3), .LOCKOUT_CYCLES(20)) dut (
    .clk(clk), .hard_rst_n(hard_rst_n), .keypad(keypad), .enter(enter), .prog(prog),
    .clr(clr), .unlock(unlock), .incorrect(incorrect), .lockout(lockout),
    .try_monitor(try_monitor), .press_monitor(press_monitor)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (press_monitor) press_cnt <= press_cnt + 1;
    if (lockout)       lo_high_cnt <= lo_high_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press_key(input int k);
    keypad = '0;
    keypad[k] = 1'b1;
    tick();
    keypad = '0;
    tick();
  endtask

  task automatic enter_pulse();
    enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
  endtask

  task automatic code(input int a, input int b, input int c, input int d);
    press_key(a); press_key(b); press_key(c); press_key(d);
    enter_pulse();
  endtask

  initial begin
    hard_rst_n = 1'b0;
    keypad = '0; enter = 1'b0; prog = 1'b0; clr = 1'b0;
    tick(); tick(); tick();
    chk("rst_unlock", unlock, 0);
    chk("rst_incorrect", incorrect, 0);
    chk("rst_lockout", lockout, 0);
    chk("rst_try", try_monitor, 0);
    chk("rst_press", press_monitor, 0);
    hard_rst_n = 1'b1;
    tick();

    // default password 0000, unlock visible one cycle after enter
    snap = press_cnt;
    press_key(0); press_key(0); press_key(0); press_key(0);
    chk("press_pulses", press_cnt - snap, 4);
    chk("pre_enter_unlock", unlock, 0);
    enter = 1'b1;
    tick();
    chk("unlock_0000", unlock, 1);
    enter = 1'b0;
    tick();

    // reprogram to 8086
    prog = 1'b1; tick(); prog = 1'b0; tick();
    chk("prog_unlock_low", unlock, 0);
    code(8, 0, 8, 6);
    chk("prog_done_locked", unlock, 0);
    chk("prog_done_incorrect", incorrect, 0);
    code(8, 0, 8, 6);
    chk("unlock_8086", unlock, 1);
    enter_pulse();
    chk("relock", unlock, 0);
    code(0, 0, 0, 0);
    chk("old_pwd_incorrect", incorrect, 1);
    chk("old_pwd_try", try_monitor, 1);
    chk("old_pwd_locked", unlock, 0);

    // delayed second key while 8 held: only the 8 counts
    keypad = '0; keypad[8] = 1'b1;
    tick();
    chk("press_clears_incorrect", incorrect, 0);
    keypad[7] = 1'b1;
    tick();
    keypad = '0;
    tick();
    press_key(0); press_key(8); press_key(6);
    enter_pulse();
    chk("delayed_double_unlock", unlock, 1);
    enter_pulse();

    // simultaneous 7+8 as first digit is invalid
    keypad = '0; keypad[8] = 1'b1; keypad[7] = 1'b1;
    tick();
    keypad = '0;
    tick();
    press_key(0); press_key(8); press_key(6);
    enter_pulse();
    chk("multikey_incorrect", incorrect, 1);
    chk("multikey_locked", unlock, 0);
    chk("multikey_try", try_monitor, 2);

    // short entry
    press_key(8); press_key(0); press_key(8);
    enter_pulse();
    chk("short_incorrect", incorrect, 1);
    chk("short_try", try_monitor, 3);

    // clr discards partial entry and clears incorrect
    press_key(1); press_key(2);
    chk("press_after_short", incorrect, 0);
    clr = 1'b1; tick(); clr = 1'b0; tick();
    chk("clr_incorrect", incorrect, 0);
    code(8, 0, 8, 6);
    chk("clr_then_unlock", unlock, 1);
    enter_pulse();

    // long entry
    press_key(8); press_key(0); press_key(8); press_key(6); press_key(6);
    enter_pulse();
    chk("long_incorrect", incorrect, 1);
    chk("long_try", try_monitor, 4);

    // key in same cycle as enter is discarded, so only 3 digits submitted
    snap = press_cnt;
    press_key(8); press_key(0); press_key(8);
    keypad = '0; keypad[6] = 1'b1; enter = 1'b1;
    tick();
    keypad = '0; enter = 1'b0;
    tick();
    chk("prio_incorrect", incorrect, 1);
    chk("prio_try", try_monitor, 5);
    chk("prio_press_count", press_cnt - snap, 3);

    // a key held for several cycles gives a single pulse
    snap = press_cnt;
    keypad = '0; keypad[8] = 1'b1;
    tick(); tick(); tick();
    keypad = '0;
    tick();
    press_key(0); press_key(8); press_key(6);
    enter_pulse();
    chk("held_key_pulses", press_cnt - snap, 4);
    chk("held_key_unlock", unlock, 1);
    enter_pulse();

`ifdef COMBO_LOCK_LOCKOUT_EN
    code(0, 0, 0, 0);
    code(0, 0, 0, 0);
    lo_high_cnt = 0;
    press_key(0); press_key(0); press_key(0); press_key(0);
    enter = 1'b1;
    tick();
    chk("lockout_entered", lockout, 1);
    chk("lockout_incorrect", incorrect, 1);
    chk("lockout_try", try_monitor, 8);
    enter = 1'b0;
    tick();
    snap = press_cnt;
    code(8, 0, 8, 6);
    chk("lockout_ignores_unlock", unlock, 0);
    chk("lockout_still_high", lockout, 1);
    chk("lockout_no_press", press_cnt - snap, 0);
    for (int i = 0; i < 100 && lockout; i++) tick();
    chk("lockout_exit", lockout, 0);
    chk("lockout_length", lo_high_cnt, 20);
    chk("lockout_exit_incorrect", incorrect, 0);
    chk("lockout_try_held", try_monitor, 8);
    code(8, 0, 8, 6);
    chk("post_lockout_unlock", unlock, 1);
    enter_pulse();
`else
    for (int i = 0; i < 5; i++) code(0, 0, 0, 0);
    chk("nolock_try", try_monitor, 10);
    chk("nolock_lockout", lockout, 0);
    chk("nolock_incorrect", incorrect, 1);
    code(8, 0, 8, 6);
    chk("nolock_retry_unlock", unlock, 1);
    enter_pulse();
`endif

    // reset mid-PROGRAM restores the zero password
    code(8, 0, 8, 6);
    prog = 1'b1; tick(); prog = 1'b0; tick();
    press_key(1); press_key(2);
    hard_rst_n = 1'b0;
    tick();
    chk("midrst_unlock", unlock, 0);
    chk("midrst_incorrect", incorrect, 0);
    chk("midrst_lockout", lockout, 0);
    chk("midrst_try", try_monitor, 0);
    chk("midrst_press", press_monitor, 0);
    hard_rst_n = 1'b1;
    tick();
    code(0, 0, 0, 0);
    chk("midrst_zero_pwd", unlock, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
